// File: rtl/vx_dispatch_queue_if.sv
`default_nettype none
// vx_dispatch_queue_if: issue-side request and per-channel execute-side buses of the dispatcher.
// master = issue stage / execute units, slave = dispatcher.
interface vx_dispatch_queue_if #(
   parameter int NUM_EX      = 5,
   parameter int EXW         = 3,
   parameter int NUM_THREADS = 4,
   parameter int DATAW       = 128
);
   localparam int TIDW = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;

   logic                          in_valid;
   logic                          in_ready;
   logic [EXW-1:0]                in_ex_type;
   logic [NUM_THREADS-1:0]        in_tmask;
   logic [DATAW-1:0]              in_data;
   logic [NUM_EX-1:0]             out_valid;
   logic [NUM_EX-1:0]             out_ready;
   logic [NUM_EX*NUM_THREADS-1:0] out_tmask;
   logic [NUM_EX*TIDW-1:0]        out_tid;
   logic [NUM_EX*DATAW-1:0]       out_data;

   modport master (
      output in_valid, in_ex_type, in_tmask, in_data, out_ready,
      input  in_ready, out_valid, out_tmask, out_tid, out_data
   );

   modport slave (
      input  in_valid, in_ex_type, in_tmask, in_data, out_ready,
      output in_ready, out_valid, out_tmask, out_tid, out_data
   );
endinterface
`default_nettype wire

// File: rtl/vx_dispatch_queue.sv
`default_nettype none
// vx_dispatch_queue: steers issued instructions into per-execute-unit FIFOs, dropping NOP/empty-mask.
// Optional macro DISPATCH_PERF_EN adds stall and per-channel issue counters.
module vx_dispatch_queue #(
   parameter int NUM_EX      = 5,
   parameter int EXW         = 3,
   parameter int NUM_THREADS = 4,
   parameter int DATAW       = 128,
   parameter int DEPTH       = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 flush,
   vx_dispatch_queue_if.slave   io,
   output logic [15:0]          drop_count
`ifdef DISPATCH_PERF_EN
   ,
   output logic [31:0]          perf_stall_cycles,
   output logic [NUM_EX*32-1:0] perf_issued
`endif
);
   localparam int TIDW = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;
   localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNTW = $clog2(DEPTH + 1);

   typedef struct packed {
      logic [NUM_THREADS-1:0] tmask;
      logic [TIDW-1:0]        tid;
      logic [DATAW-1:0]       data;
   } entry_t;

   logic [EXW-1:0]    ex_type;
   logic              is_nop, is_empty, is_drop, sel_full;
   logic [NUM_EX-1:0] full, push;
   logic [TIDW-1:0]   lead_tid;
   logic [15:0]       drop_q, drop_d;
   entry_t            in_entry;

   assign ex_type  = io.in_ex_type;
   assign is_nop   = int'(ex_type) >= NUM_EX;
   assign is_empty = (io.in_tmask == '0);
   assign is_drop  = is_nop | is_empty;

   always_comb begin
      lead_tid = '0;
      for (int t = NUM_THREADS - 1; t >= 0; t--)
         if (io.in_tmask[t]) lead_tid = TIDW'(t);
   end

   always_comb begin
      sel_full = 1'b0;
      for (int k = 0; k < NUM_EX; k++)
         if (int'(ex_type) == k) sel_full = full[k];
   end

   // Drops always complete; only real pushes see fullness and flush, never out_ready.
   assign io.in_ready = is_drop | (~sel_full & ~flush);
   assign in_entry    = '{tmask: io.in_tmask, tid: lead_tid, data: io.in_data};

   for (genvar k = 0; k < NUM_EX; k++) begin : g_chan
      logic [PTRW-1:0] rd_q, rd_d, wr_q, wr_d;
      logic [CNTW-1:0] cnt_q, cnt_d;
      entry_t          mem_q [DEPTH];
      entry_t          head;
      logic            pop;

      assign push[k] = io.in_valid & ~is_drop & ~flush & ~full[k] & (int'(ex_type) == k);
      assign pop     = io.out_valid[k] & io.out_ready[k];
      assign full[k] = (cnt_q == CNTW'(DEPTH));

      always_comb begin
         rd_d  = rd_q;
         wr_d  = wr_q;
         cnt_d = cnt_q;
         if (flush) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
         end else begin
            if (push[k]) wr_d = (wr_q == PTRW'(DEPTH - 1)) ? '0 : wr_q + PTRW'(1);
            if (pop)     rd_d = (rd_q == PTRW'(DEPTH - 1)) ? '0 : rd_q + PTRW'(1);
            if (push[k] & ~pop)      cnt_d = cnt_q + CNTW'(1);
            else if (~push[k] & pop) cnt_d = cnt_q - CNTW'(1);
         end
      end

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
            for (int e = 0; e < DEPTH; e++) mem_q[e] <= '0;
         end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
            if (push[k]) mem_q[wr_q] <= in_entry;
         end
      end

      assign head                                       = mem_q[rd_q];
      assign io.out_valid[k]                            = (cnt_q != '0);
      assign io.out_tmask[k*NUM_THREADS +: NUM_THREADS] = head.tmask;
      assign io.out_tid[k*TIDW +: TIDW]                 = head.tid;
      assign io.out_data[k*DATAW +: DATAW]              = head.data;
   end

   always_comb begin
      drop_d = drop_q;
      if (io.in_valid & is_drop & (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) drop_q <= '0;
      else        drop_q <= drop_d;
   end

   assign drop_count = drop_q;

`ifdef DISPATCH_PERF_EN
   logic [31:0]          stall_q;
   logic [NUM_EX*32-1:0] issued_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_q  <= '0;
         issued_q <= '0;
      end else begin
         if (io.in_valid & ~io.in_ready) stall_q <= stall_q + 32'd1;
         for (int k = 0; k < NUM_EX; k++)
            if (push[k]) issued_q[k*32 +: 32] <= issued_q[k*32 +: 32] + 32'd1;
      end
   end

   assign perf_stall_cycles = stall_q;
   assign perf_issued       = issued_q;
`endif
endmodule
`default_nettype wire

// File: tb/tb_vx_dispatch_queue.sv
`default_nettype none
// tb_vx_dispatch_queue: scoreboard bench; per-channel expected queues fed by the driver,
// drained and compared by a negedge monitor.
module tb_vx_dispatch_queue;
   localparam int NUM_EX = 5;
   localparam int EXW    = 3;
   localparam int NT     = 4;
   localparam int DATAW  = 128;
   localparam int DEPTH  = 2;
   localparam int TIDW   = 2;

   logic        clk   = 1'b0;
   logic        reset = 1'b0;
   logic        flush = 1'b0;
   logic [15:0] drop_count;

   vx_dispatch_queue_if #(.NUM_EX(NUM_EX), .EXW(EXW), .NUM_THREADS(NT), .DATAW(DATAW)) io ();

`ifdef DISPATCH_PERF_EN
   logic [31:0]          perf_stall;
   logic [NUM_EX*32-1:0] perf_issued;
   int                   exp_stall;
   int                   exp_issued [NUM_EX];
`endif

   vx_dispatch_queue #(
      .NUM_EX(NUM_EX), .EXW(EXW), .NUM_THREADS(NT), .DATAW(DATAW), .DEPTH(DEPTH)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .flush             (flush),
      .io                (io),
      .drop_count        (drop_count)
`ifdef DISPATCH_PERF_EN
      ,
      .perf_stall_cycles (perf_stall),
      .perf_issued       (perf_issued)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [NT-1:0]    tmask;
      int               tid;
      logic [DATAW-1:0] data;
   } exp_t;

   exp_t q [NUM_EX][$];
   int   n_cmp    = 0;
   int   n_bad    = 0;
   int   exp_drop = 0;
   bit   last_acc = 1'b0;

   task automatic chk(input string name, input logic [DATAW-1:0] act, input logic [DATAW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: actual=%0h expected=%0h", name, $time, act, exp);
      end
   endtask

   function automatic int lowest_set(input logic [NT-1:0] m);
      for (int t = 0; t < NT; t++) if (m[t]) return t;
      return 0;
   endfunction

   task automatic clear_model();
      for (int k = 0; k < NUM_EX; k++) q[k].delete();
   endtask

   // Monitor: compares what the DUT presents against the model, then retires popped entries.
   exp_t h;
   bit   exp_rdy;
   always @(negedge clk) begin
      if (!reset) begin
         chk("rst_out_valid", DATAW'(io.out_valid), '0);
         chk("rst_drop_count", DATAW'(drop_count), '0);
      end else begin
         if (int'(io.in_ex_type) >= NUM_EX || io.in_tmask == '0) exp_rdy = 1'b1;
         else exp_rdy = !flush && (q[io.in_ex_type].size() < DEPTH);
         chk("in_ready", DATAW'(io.in_ready), DATAW'(exp_rdy));
         chk("drop_count", DATAW'(drop_count), DATAW'(exp_drop));
`ifdef DISPATCH_PERF_EN
         chk("perf_stall", DATAW'(perf_stall), DATAW'(exp_stall));
         for (int k = 0; k < NUM_EX; k++)
            chk("perf_issued", DATAW'(perf_issued[k*32 +: 32]), DATAW'(exp_issued[k]));
`endif
         for (int k = 0; k < NUM_EX; k++) begin
            chk($sformatf("out_valid[%0d]", k), DATAW'(io.out_valid[k]), DATAW'(q[k].size() > 0));
            if (io.out_valid[k] && q[k].size() > 0) begin
               h = q[k][0];
               chk($sformatf("out_tmask[%0d]", k), DATAW'(io.out_tmask[k*NT +: NT]), DATAW'(h.tmask));
               chk($sformatf("out_tid[%0d]", k), DATAW'(io.out_tid[k*TIDW +: TIDW]), DATAW'(h.tid));
               chk($sformatf("out_data[%0d]", k), io.out_data[k*DATAW +: DATAW], h.data);
               if (io.out_ready[k]) void'(q[k].pop_front());
            end
         end
      end
   end

   // One cycle of stimulus; the expected entry is queued at the edge that accepts it.
   task automatic step(input bit v, input logic [EXW-1:0] ex, input logic [NT-1:0] tm,
                       input logic [DATAW-1:0] d, input bit fl, input logic [NUM_EX-1:0] rdy);
      bit acc, drop;
      io.in_valid   = v;
      io.in_ex_type = ex;
      io.in_tmask   = tm;
      io.in_data    = d;
      flush         = fl;
      io.out_ready  = rdy;
      @(negedge clk);
      acc  = v && io.in_ready;
      drop = (int'(ex) >= NUM_EX) || (tm == '0);
      @(posedge clk);
      if (fl) clear_model();
`ifdef DISPATCH_PERF_EN
      if (v && !acc) exp_stall++;
      if (acc && !drop) exp_issued[ex]++;
`endif
      if (acc && drop && exp_drop < 16'hFFFF) exp_drop++;
      if (acc && !drop) q[ex].push_back('{tmask: tm, tid: lowest_set(tm), data: d});
      last_acc = acc;
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, 1'b0, '1);
   endtask

   task automatic do_reset();
      io.in_valid = 1'b0;
      flush       = 1'b0;
      @(posedge clk);
      #1 reset = 1'b0;
      clear_model();
      exp_drop = 0;
`ifdef DISPATCH_PERF_EN
      exp_stall = 0;
      for (int k = 0; k < NUM_EX; k++) exp_issued[k] = 0;
`endif
      repeat (2) @(negedge clk);
      @(posedge clk);
      #1 reset = 1'b1;
      last_acc = 1'b0;
   endtask

   task automatic rand_phase(input int n, input int rdy_pct);
      bit                  v, fl;
      logic [EXW-1:0]      ex;
      logic [NT-1:0]       tm;
      logic [DATAW-1:0]    d;
      logic [NUM_EX-1:0]   rdy;
      v = 1'b0; ex = '0; tm = '0; d = '0;
      last_acc = 1'b0;
      for (int i = 0; i < n; i++) begin
         if (!(v && !last_acc)) begin
            v  = $urandom_range(0, 99) < 80;
            ex = ($urandom_range(0, 9) == 0) ? EXW'($urandom_range(NUM_EX, (1 << EXW) - 1))
                                             : EXW'($urandom_range(0, NUM_EX - 1));
            tm = ($urandom_range(0, 9) == 0) ? '0 : NT'($urandom);
            d  = {$urandom, $urandom, $urandom, $urandom};
         end
         fl = $urandom_range(0, 99) < 3;
         for (int k = 0; k < NUM_EX; k++) rdy[k] = $urandom_range(0, 99) < rdy_pct;
         step(v, ex, tm, d, fl, rdy);
      end
   endtask

   logic [DATAW-1:0] dv;
   initial begin
      io.in_valid   = 1'b0;
      io.in_ex_type = '0;
      io.in_tmask   = '0;
      io.in_data    = '0;
      io.out_ready  = '0;
`ifdef DISPATCH_PERF_EN
      exp_stall = 0;
      for (int k = 0; k < NUM_EX; k++) exp_issued[k] = 0;
`endif
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;

      // Single dispatch to channel 2, leader thread 1.
      step(1'b1, 3'd2, 4'b0110, 128'hA5, 1'b0, '1);
      idle(2);

      // Channel 0 backpressured: two accepts then stall, drain in order.
      dv = 128'd100;
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 3'd0, 4'hF, dv, 1'b0, 5'b11110);
         if (last_acc) dv++;
      end
      for (int i = 0; i < 6; i++) begin
         step(dv < 128'd104, 3'd0, 4'hF, dv, 1'b0, '1);
         if (last_acc) dv++;
      end
      idle(2);

      // NOP and empty mask both dropped and counted.
      step(1'b1, 3'd7, 4'hF, 128'd1, 1'b0, '1);
      step(1'b1, 3'd1, 4'h0, 128'd2, 1'b0, '1);
      idle(2);

      // Fill channels 0 and 3, flush with a pending ch3 request, then resume.
      for (int i = 0; i < 2; i++) step(1'b1, 3'd0, 4'b1000, 128'd10 + 128'(i), 1'b0, '0);
      for (int i = 0; i < 2; i++) step(1'b1, 3'd3, 4'b0100, 128'd20 + 128'(i), 1'b0, '0);
      step(1'b1, 3'd3, 4'hF, 128'd55, 1'b1, '0);
      step(1'b1, 3'd3, 4'hF, 128'd55, 1'b0, '1);
      idle(2);

      // Channel 1 stalled full; channel 4 keeps streaming.
      for (int i = 0; i < 2; i++) step(1'b1, 3'd1, 4'b0010, 128'd30 + 128'(i), 1'b0, 5'b11101);
      for (int i = 0; i < 4; i++) step(1'b1, 3'd4, 4'b1100, 128'd40 + 128'(i), 1'b0, 5'b11101);
      idle(3);

      rand_phase(600, 90);
      rand_phase(600, 30);
      do_reset();
      rand_phase(600, 60);
      idle(4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/vx_dispatch_queue.md
Name: vx_dispatch_queue

Overview:
- Parametrised issue-to-execute dispatcher: steers one decoded instruction per cycle from the issue stage to one of NUM_EX execute-unit channels, selected by ex_type.
- Each channel has its own DEPTH-entry FIFO, so a stalled unit does not block others until its FIFO fills.
- Computes the leader thread id (lowest active lane) per instruction, drops NOPs and empty-mask instructions, and supports a synchronous pipeline flush.
- Sits between the issue stage (ibuffer + GPR read) and the ALU/LSU/CSR/FPU/GPU request interfaces.

Parameters:
- NUM_EX, 5, number of execute channels; ex_type values 0..NUM_EX-1 are valid.
- EXW, 3, ex_type width; must satisfy 2^EXW >= NUM_EX.
- NUM_THREADS, 4, lanes per warp; width of tmask.
- DATAW, 128, opaque payload width per instruction (wid, PC, operands, ...).
- DEPTH, 2, entries per channel FIFO; legal range 1..16.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of all channel FIFOs.
- in_valid  in  1  issue request valid.
- in_ready  out  1  request accepted this cycle.
- in_ex_type  in  EXW  target channel.
- in_tmask  in  NUM_THREADS  active-thread mask.
- in_data  in  DATAW  payload.
- out_valid  out  NUM_EX  per-channel valid.
- out_ready  in  NUM_EX  per-channel ready.
- out_tmask  out  NUM_EX*NUM_THREADS  per-channel tmask; channel k at [k*NUM_THREADS +: NUM_THREADS].
- out_tid  out  NUM_EX*clog2(NUM_THREADS)  per-channel leader thread id.
- out_data  out  NUM_EX*DATAW  per-channel payload.
- drop_count  out  16  number of dropped instructions (NOP plus empty-mask); saturates at 16'hFFFF.

Behaviour:
- Reset (reset=0, async): all FIFOs empty; out_valid=0; out_tmask, out_tid, out_data=0; drop_count=0. Reset asserted mid-transfer loses all queued entries.
- Transfer rules:
  - Input transfer when in_valid & in_ready; output transfer on channel k when out_valid[k] & out_ready[k].
  - The producer holds in_* stable while in_valid & !in_ready.
- Ready / drop rules:
  - in_ex_type >= NUM_EX (NOP): in_ready=1; instruction dropped; drop_count+1.
  - in_tmask == 0: in_ready=1; instruction dropped; drop_count+1.
  - Otherwise in_ready = !full[in_ex_type] & !flush.
  - in_ready is independent of out_ready: no combinational in/out path.
  - Consequence: with a full FIFO, a same-cycle pop does not enable a push.
- Leader thread id: tid = index of the lowest set bit of in_tmask. It is computed at enqueue and stored with the entry.
- FIFO per channel:
  - Circular buffer with rd/wr pointers and a count from 0 to DEPTH.
  - Pointers wrap from DEPTH-1 to 0; DEPTH need not be a power of two.
  - Outputs are registered: an entry enqueued at cycle N appears on out_* at cycle N+1 at the earliest. Minimum latency 1 cycle.
  - Simultaneous push and pop on a non-full, non-empty FIFO: count unchanged, both pointers advance.
  - Full-throughput streaming (one transfer per cycle per channel) requires DEPTH >= 2; DEPTH=1 gives 1 transfer per 2 cycles.
  - out_data, out_tid and out_tmask are held stable while out_valid[k] & !out_ready[k].
- Flush:
  - In the cycle after flush=1, all FIFOs are empty and out_valid=0.
  - During flush, in_ready=0 for valid channels, so nothing is accepted.
  - NOP and empty-mask drops still complete and are counted.
  - drop_count is not cleared by flush.
- Ordering: FIFO order per channel. No ordering guarantee across channels.

Optional Feature:
- DISPATCH_PERF_EN defined adds the following outputs:
  - perf_stall_cycles (32 bits): counts cycles with in_valid & !in_ready.
  - perf_issued (NUM_EX*32 bits): per-channel count of accepted instructions.
  - All counters wrap; all reset to 0; none are cleared by flush.
- Undefined: these ports and counters are absent; core behaviour is identical.

Test Plan:
- Reset, then ex_type=2, tmask=4'b0110, data=0xA5 -> next cycle out_valid=5'b00100, out_tid[2]=1, out_data[2]=0xA5; out_valid=0 while reset=0.
- ex_type=0 streamed 4 cycles with out_ready[0]=0, DEPTH=2 -> in_ready drops after 2 accepts; raise out_ready -> entries emerge in order, in_ready reasserts one cycle after the first pop.
- ex_type=7 (NOP), then tmask=0 with ex_type=1 -> in_ready=1 both cycles, out_valid stays 0, drop_count=2.
- Fill ch0 and ch3 with 2 entries each, assert flush with in_valid on ex_type=3 -> in_ready=0, next cycle out_valid=0, later pushes accepted normally.
- Channel 1 stalled full while ex_type=4 requests arrive -> ch4 accepts and outputs each cycle unaffected (DEPTH=2, out_ready[4]=1).
- With DISPATCH_PERF_EN, 3 stalled cycles then 5 issues to ch2 -> perf_stall_cycles=3, perf_issued[2]=5.
